// File: rtl/riffa_pkg.sv
// Shared RIFFA register map, signal widths and read FSM states.
// Offsets 0..7 are host-writable, 8..15 are host-readable.
package riffa_pkg;

  localparam int OFFSET_W           = 4;
  localparam int TAG_W              = 8;
  localparam int SIG_TXRLEN_W       = 32;
  localparam int SIG_OFFLAST_W      = 32;
  localparam int SIG_RXDONELEN_W    = 32;
  localparam int SIG_TXDONELEN_W    = 32;
  localparam int SIG_CORESETTINGS_W = 32;

  localparam logic [OFFSET_W-1:0] ADDR_SGRX_LEN      = 4'd0;
  localparam logic [OFFSET_W-1:0] ADDR_SGRX_ADDRLO   = 4'd1;
  localparam logic [OFFSET_W-1:0] ADDR_SGRX_ADDRHI   = 4'd2;
  localparam logic [OFFSET_W-1:0] ADDR_RX_LEN        = 4'd3;
  localparam logic [OFFSET_W-1:0] ADDR_RX_OFFLAST    = 4'd4;
  localparam logic [OFFSET_W-1:0] ADDR_SGTX_LEN      = 4'd5;
  localparam logic [OFFSET_W-1:0] ADDR_SGTX_ADDRLO   = 4'd6;
  localparam logic [OFFSET_W-1:0] ADDR_SGTX_ADDRHI   = 4'd7;
  localparam logic [OFFSET_W-1:0] ADDR_TX_LEN        = 4'd8;
  localparam logic [OFFSET_W-1:0] ADDR_TX_OFFLAST    = 4'd9;
  localparam logic [OFFSET_W-1:0] ADDR_CORESETTINGS  = 4'd10;
  localparam logic [OFFSET_W-1:0] ADDR_INTR_VECTOR_0 = 4'd11;
  localparam logic [OFFSET_W-1:0] ADDR_INTR_VECTOR_1 = 4'd12;
  localparam logic [OFFSET_W-1:0] ADDR_RX_LEN_XFERD  = 4'd13;
  localparam logic [OFFSET_W-1:0] ADDR_TX_LEN_XFERD  = 4'd14;
  localparam logic [OFFSET_W-1:0] ADDR_FPGA_NAME     = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    CPL
  } rd_state_t;

endpackage

// File: rtl/riffa_chnl_regs.sv
// Per-channel write-side register slice: SG lists and RX setup.
// Start/valid strobes fire the cycle after the triggering write.
module riffa_chnl_regs
  import riffa_pkg::*;
(
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [OFFSET_W-1:0]      wr_offset,
  input  logic [31:0]              wr_data,
  output logic                     rx_start,
  output logic [SIG_TXRLEN_W-1:0]  rx_len,
  output logic [SIG_OFFLAST_W-1:0] rx_offlast,
  output logic                     sgrx_valid,
  output logic                     sgtx_valid,
  output logic [63:0]              sgrx_addr,
  output logic [63:0]              sgtx_addr,
  output logic [31:0]              sgrx_len,
  output logic [31:0]              sgtx_len
);

  // Latch setup registers and raise one-cycle strobes.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_start   <= 1'b0;
      rx_len     <= '0;
      rx_offlast <= '0;
      sgrx_valid <= 1'b0;
      sgtx_valid <= 1'b0;
      sgrx_addr  <= '0;
      sgtx_addr  <= '0;
      sgrx_len   <= '0;
      sgtx_len   <= '0;
    end else begin
      rx_start   <= 1'b0;
      sgrx_valid <= 1'b0;
      sgtx_valid <= 1'b0;
      if (wr_en) begin
        unique case (1'b1)
          wr_offset == ADDR_SGRX_ADDRLO:
            sgrx_addr[31:0] <= wr_data;
          wr_offset == ADDR_SGRX_ADDRHI:
            sgrx_addr[63:32] <= wr_data;
          wr_offset == ADDR_SGRX_LEN: begin
            sgrx_len   <= wr_data;
            sgrx_valid <= 1'b1;
          end
          wr_offset == ADDR_SGTX_ADDRLO:
            sgtx_addr[31:0] <= wr_data;
          wr_offset == ADDR_SGTX_ADDRHI:
            sgtx_addr[63:32] <= wr_data;
          wr_offset == ADDR_SGTX_LEN: begin
            sgtx_len   <= wr_data;
            sgtx_valid <= 1'b1;
          end
          wr_offset == ADDR_RX_LEN:
            rx_len <= SIG_TXRLEN_W'(wr_data);
          wr_offset == ADDR_RX_OFFLAST: begin
            rx_offlast <= SIG_OFFLAST_W'(wr_data);
            rx_start   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/riffa_chnl_reg_ctrl.sv
// Host register controller: write decode to channel slices,
// read completion FSM with TX ack and interrupt clear-on-read.
module riffa_chnl_reg_ctrl
  import riffa_pkg::*;
#(
  parameter int C_NUM_CHNL = 12,
  parameter int C_CHNL_W   = 4
) (
  input  logic                                  clk,
  input  logic                                  aresetn,
  input  logic                                  wr_valid,
  input  logic [C_CHNL_W-1:0]                   wr_chnl,
  input  logic [OFFSET_W-1:0]                   wr_offset,
  input  logic [31:0]                           wr_data,
  input  logic                                  rd_valid,
  output logic                                  rd_ready,
  input  logic [C_CHNL_W-1:0]                   rd_chnl,
  input  logic [OFFSET_W-1:0]                   rd_offset,
  input  logic [TAG_W-1:0]                      rd_tag,
  output logic                                  cpl_valid,
  input  logic                                  cpl_ready,
  output logic [31:0]                           cpl_data,
  output logic [TAG_W-1:0]                      cpl_tag,
  output logic [C_NUM_CHNL-1:0]                 rx_start,
  output logic [C_NUM_CHNL*SIG_TXRLEN_W-1:0]    rx_len,
  output logic [C_NUM_CHNL*SIG_OFFLAST_W-1:0]   rx_offlast,
  output logic [C_NUM_CHNL-1:0]                 sgrx_valid,
  output logic [C_NUM_CHNL-1:0]                 sgtx_valid,
  output logic [C_NUM_CHNL*64-1:0]              sgrx_addr,
  output logic [C_NUM_CHNL*64-1:0]              sgtx_addr,
  output logic [C_NUM_CHNL*32-1:0]              sgrx_len,
  output logic [C_NUM_CHNL*32-1:0]              sgtx_len,
  input  logic [C_NUM_CHNL*SIG_TXRLEN_W-1:0]    tx_len_i,
  input  logic [C_NUM_CHNL*SIG_OFFLAST_W-1:0]   tx_offlast_i,
  output logic [C_NUM_CHNL-1:0]                 tx_ack,
  input  logic [C_NUM_CHNL*SIG_RXDONELEN_W-1:0] rx_done_len_i,
  input  logic [C_NUM_CHNL*SIG_TXDONELEN_W-1:0] tx_done_len_i,
  input  logic [SIG_CORESETTINGS_W-1:0]         core_settings_i,
  input  logic [31:0]                           fpga_name_i,
  input  logic [2*C_NUM_CHNL-1:0]               intr_i,
  output logic [2*C_NUM_CHNL-1:0]               intr_clr
);

  localparam int NSLOT  = 2**C_CHNL_W;
  localparam int INTR_W = 2*C_NUM_CHNL;

  rd_state_t           state;
  rd_state_t           state_nxt;
  logic [C_CHNL_W-1:0] cap_chnl;
  logic [OFFSET_W-1:0] cap_off;
  logic [TAG_W-1:0]    cap_tag;
  logic [31:0]         rd_data;
  logic [63:0]         intr_ext;

  logic [31:0] tx_len_a  [NSLOT];
  logic [31:0] tx_ofl_a  [NSLOT];
  logic [31:0] rx_done_a [NSLOT];
  logic [31:0] tx_done_a [NSLOT];

  assign intr_ext = 64'(intr_i);

  // Unpopulated slots read as zero, so an out-of-range index needs no guard.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < C_NUM_CHNL) begin : g_on
      assign tx_len_a[i]  = 32'(tx_len_i[i*SIG_TXRLEN_W +: SIG_TXRLEN_W]);
      assign tx_ofl_a[i]  = 32'(tx_offlast_i[i*SIG_OFFLAST_W +: SIG_OFFLAST_W]);
      assign rx_done_a[i] = 32'(rx_done_len_i[i*SIG_RXDONELEN_W +: SIG_RXDONELEN_W]);
      assign tx_done_a[i] = 32'(tx_done_len_i[i*SIG_TXDONELEN_W +: SIG_TXDONELEN_W]);
    end else begin : g_off
      assign tx_len_a[i]  = '0;
      assign tx_ofl_a[i]  = '0;
      assign rx_done_a[i] = '0;
      assign tx_done_a[i] = '0;
    end
  end

  for (genvar i = 0; i < C_NUM_CHNL; i++) begin : g_ch
    riffa_chnl_regs u_regs (
      .clk        (clk),
      .aresetn    (aresetn),
      .wr_en      (wr_valid && (wr_chnl == C_CHNL_W'(i))),
      .wr_offset  (wr_offset),
      .wr_data    (wr_data),
      .rx_start   (rx_start[i]),
      .rx_len     (rx_len[i*SIG_TXRLEN_W +: SIG_TXRLEN_W]),
      .rx_offlast (rx_offlast[i*SIG_OFFLAST_W +: SIG_OFFLAST_W]),
      .sgrx_valid (sgrx_valid[i]),
      .sgtx_valid (sgtx_valid[i]),
      .sgrx_addr  (sgrx_addr[i*64 +: 64]),
      .sgtx_addr  (sgtx_addr[i*64 +: 64]),
      .sgrx_len   (sgrx_len[i*32 +: 32]),
      .sgtx_len   (sgtx_len[i*32 +: 32])
    );
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, handshakes and CAPT side-effect pulses.
  always_comb begin
    state_nxt = state;
    rd_ready  = 1'b0;
    cpl_valid = 1'b0;
    tx_ack    = '0;
    intr_clr  = '0;
    unique case (state)
      IDLE: begin
        rd_ready = 1'b1;
        if (rd_valid) state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = CPL;
        if (cap_off == ADDR_TX_OFFLAST) begin
          for (int i = 0; i < C_NUM_CHNL; i++)
            tx_ack[i] = (cap_chnl == C_CHNL_W'(i));
        end
        if (cap_off == ADDR_INTR_VECTOR_0)
          intr_clr = INTR_W'(intr_ext[31:0]);
      end
      CPL: begin
        cpl_valid = 1'b1;
        if (cpl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data mux for the captured request.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      cap_off == ADDR_TX_LEN:        rd_data = tx_len_a[cap_chnl];
      cap_off == ADDR_TX_OFFLAST:    rd_data = tx_ofl_a[cap_chnl];
      cap_off == ADDR_RX_LEN_XFERD:  rd_data = rx_done_a[cap_chnl];
      cap_off == ADDR_TX_LEN_XFERD:  rd_data = tx_done_a[cap_chnl];
      cap_off == ADDR_CORESETTINGS:  rd_data = 32'(core_settings_i);
      cap_off == ADDR_FPGA_NAME:     rd_data = fpga_name_i;
      cap_off == ADDR_INTR_VECTOR_0: rd_data = intr_ext[31:0];
      cap_off == ADDR_INTR_VECTOR_1: rd_data = intr_ext[63:32];
      default: ;
    endcase
  end

  // Capture the request, then register the completion at end of CAPT.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cap_chnl <= '0;
      cap_off  <= '0;
      cap_tag  <= '0;
      cpl_data <= '0;
      cpl_tag  <= '0;
    end else begin
      if (state == IDLE && rd_valid) begin
        cap_chnl <= rd_chnl;
        cap_off  <= rd_offset;
        cap_tag  <= rd_tag;
      end
      if (state == CAPT) begin
        cpl_data <= rd_data;
        cpl_tag  <= cap_tag;
      end
    end
  end

endmodule

// File: tb/tb_riffa_chnl_reg_ctrl.sv
// Randomized bench for riffa_chnl_reg_ctrl with a behavioural
// register-map model plus directed literal scenarios.
module tb_riffa_chnl_reg_ctrl;
  import riffa_pkg::*;

  localparam int N  = 12;
  localparam int CW = 4;

  logic            clk;
  logic            aresetn;
  logic            wr_valid;
  logic [CW-1:0]   wr_chnl;
  logic [3:0]      wr_offset;
  logic [31:0]     wr_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [CW-1:0]   rd_chnl;
  logic [3:0]      rd_offset;
  logic [7:0]      rd_tag;
  logic            cpl_valid;
  logic            cpl_ready;
  logic [31:0]     cpl_data;
  logic [7:0]      cpl_tag;
  logic [N-1:0]    rx_start;
  logic [N*32-1:0] rx_len;
  logic [N*32-1:0] rx_offlast;
  logic [N-1:0]    sgrx_valid;
  logic [N-1:0]    sgtx_valid;
  logic [N*64-1:0] sgrx_addr;
  logic [N*64-1:0] sgtx_addr;
  logic [N*32-1:0] sgrx_len;
  logic [N*32-1:0] sgtx_len;
  logic [N*32-1:0] tx_len_i;
  logic [N*32-1:0] tx_offlast_i;
  logic [N-1:0]    tx_ack;
  logic [N*32-1:0] rx_done_len_i;
  logic [N*32-1:0] tx_done_len_i;
  logic [31:0]     core_settings_i;
  logic [31:0]     fpga_name_i;
  logic [2*N-1:0]  intr_i;
  logic [2*N-1:0]  intr_clr;

  riffa_chnl_reg_ctrl #(.C_NUM_CHNL(N), .C_CHNL_W(CW)) dut (
    .clk(clk), .aresetn(aresetn),
    .wr_valid(wr_valid), .wr_chnl(wr_chnl),
    .wr_offset(wr_offset), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_chnl(rd_chnl), .rd_offset(rd_offset), .rd_tag(rd_tag),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_data(cpl_data), .cpl_tag(cpl_tag),
    .rx_start(rx_start), .rx_len(rx_len), .rx_offlast(rx_offlast),
    .sgrx_valid(sgrx_valid), .sgtx_valid(sgtx_valid),
    .sgrx_addr(sgrx_addr), .sgtx_addr(sgtx_addr),
    .sgrx_len(sgrx_len), .sgtx_len(sgtx_len),
    .tx_len_i(tx_len_i), .tx_offlast_i(tx_offlast_i),
    .tx_ack(tx_ack),
    .rx_done_len_i(rx_done_len_i), .tx_done_len_i(tx_done_len_i),
    .core_settings_i(core_settings_i), .fpga_name_i(fpga_name_i),
    .intr_i(intr_i), .intr_clr(intr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] m_sgrx_addr [N];
  logic [63:0] m_sgtx_addr [N];
  logic [31:0] m_sgrx_len  [N];
  logic [31:0] m_sgtx_len  [N];
  logic [31:0] m_rx_len    [N];
  logic [31:0] m_rx_ofl    [N];
  logic [N-1:0] m_sgrx_v, m_sgtx_v, m_rx_st;
  int          m_phase;
  int          m_chnl;
  logic [3:0]  m_off;
  logic [7:0]  m_tag, m_tagq;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_read(int ch, logic [3:0] off);
    logic [63:0] iv;
    iv = 64'(intr_i);
    if (off == ADDR_CORESETTINGS)  return core_settings_i;
    if (off == ADDR_FPGA_NAME)     return fpga_name_i;
    if (off == ADDR_INTR_VECTOR_0) return iv[31:0];
    if (off == ADDR_INTR_VECTOR_1) return iv[63:32];
    if (ch >= N) return 32'd0;
    if (off == ADDR_TX_LEN)        return tx_len_i[ch*32 +: 32];
    if (off == ADDR_TX_OFFLAST)    return tx_offlast_i[ch*32 +: 32];
    if (off == ADDR_RX_LEN_XFERD)  return rx_done_len_i[ch*32 +: 32];
    if (off == ADDR_TX_LEN_XFERD)  return tx_done_len_i[ch*32 +: 32];
    return 32'd0;
  endfunction

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N; i++) begin
        m_sgrx_addr[i] <= '0; m_sgtx_addr[i] <= '0;
        m_sgrx_len[i]  <= '0; m_sgtx_len[i]  <= '0;
        m_rx_len[i]    <= '0; m_rx_ofl[i]    <= '0;
      end
      m_sgrx_v <= '0; m_sgtx_v <= '0; m_rx_st <= '0;
      m_phase <= 0; m_chnl <= 0; m_off <= '0;
      m_tag <= '0; m_tagq <= '0; m_data <= '0;
    end else begin
      m_sgrx_v <= '0; m_sgtx_v <= '0; m_rx_st <= '0;
      if (wr_valid && int'(wr_chnl) < N) begin
        case (wr_offset)
          ADDR_SGRX_ADDRLO: m_sgrx_addr[wr_chnl][31:0]  <= wr_data;
          ADDR_SGRX_ADDRHI: m_sgrx_addr[wr_chnl][63:32] <= wr_data;
          ADDR_SGTX_ADDRLO: m_sgtx_addr[wr_chnl][31:0]  <= wr_data;
          ADDR_SGTX_ADDRHI: m_sgtx_addr[wr_chnl][63:32] <= wr_data;
          ADDR_RX_LEN:      m_rx_len[wr_chnl] <= wr_data;
          ADDR_SGRX_LEN: begin
            m_sgrx_len[wr_chnl] <= wr_data;
            m_sgrx_v <= N'(1) << wr_chnl;
          end
          ADDR_SGTX_LEN: begin
            m_sgtx_len[wr_chnl] <= wr_data;
            m_sgtx_v <= N'(1) << wr_chnl;
          end
          ADDR_RX_OFFLAST: begin
            m_rx_ofl[wr_chnl] <= wr_data;
            m_rx_st <= N'(1) << wr_chnl;
          end
          default: ;
        endcase
      end
      case (m_phase)
        0: if (rd_valid) begin
          m_phase <= 1;
          m_chnl  <= int'(rd_chnl);
          m_off   <= rd_offset;
          m_tag   <= rd_tag;
        end
        1: begin
          m_data  <= ref_read(m_chnl, m_off);
          m_tagq  <= m_tag;
          m_phase <= 2;
        end
        default: if (cpl_ready) m_phase <= 0;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
  endtask

  task automatic compare_all();
    logic [N-1:0]   e_ack;
    logic [2*N-1:0] e_clr;
    logic [63:0]    iv;
    iv    = 64'(intr_i);
    e_ack = '0;
    e_clr = '0;
    if (m_phase == 1 && m_off == ADDR_TX_OFFLAST && m_chnl < N)
      e_ack = N'(1) << m_chnl;
    if (m_phase == 1 && m_off == ADDR_INTR_VECTOR_0)
      e_clr = (2*N)'(iv[31:0]);
    chk("m_rd_ready", rd_ready, m_phase == 0);
    chk("m_cpl_valid", cpl_valid, m_phase == 2);
    if (m_phase == 2) begin
      chk("m_cpl_data", cpl_data, m_data);
      chk("m_cpl_tag", cpl_tag, m_tagq);
    end
    chk("m_tx_ack", tx_ack, e_ack);
    chk("m_intr_clr", intr_clr, e_clr);
    chk("m_sgrx_valid", sgrx_valid, m_sgrx_v);
    chk("m_sgtx_valid", sgtx_valid, m_sgtx_v);
    chk("m_rx_start", rx_start, m_rx_st);
    for (int i = 0; i < N; i++) begin
      chk("m_sgrx_addr", sgrx_addr[i*64 +: 64], m_sgrx_addr[i]);
      chk("m_sgtx_addr", sgtx_addr[i*64 +: 64], m_sgtx_addr[i]);
      chk("m_sgrx_len", sgrx_len[i*32 +: 32], m_sgrx_len[i]);
      chk("m_sgtx_len", sgtx_len[i*32 +: 32], m_sgtx_len[i]);
      chk("m_rx_len", rx_len[i*32 +: 32], m_rx_len[i]);
      chk("m_rx_offlast", rx_offlast[i*32 +: 32], m_rx_ofl[i]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [CW-1:0] ch, input logic [3:0] off,
                    input logic [31:0] d);
    wr_valid = 1'b1; wr_chnl = ch; wr_offset = off; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [CW-1:0] ch, input logic [3:0] off,
                    input logic [7:0] tag);
    int k;
    k = 0;
    while (!rd_ready && k < 20) begin
      step();
      k++;
    end
    chk("rd_ready_wait", rd_ready, 1'b1);
    rd_valid = 1'b1; rd_chnl = ch; rd_offset = off; rd_tag = tag;
    step();
    rd_valid = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      tx_len_i[i*32 +: 32]      = $urandom();
      tx_offlast_i[i*32 +: 32]  = $urandom();
      rx_done_len_i[i*32 +: 32] = $urandom();
      tx_done_len_i[i*32 +: 32] = $urandom();
    end
    core_settings_i = $urandom();
    fpga_name_i     = $urandom();
    r = {$urandom(), $urandom()};
    intr_i = r[2*N-1:0];
  endtask

  initial begin
    aresetn = 1'b0;
    wr_valid = 0; wr_chnl = '0; wr_offset = '0; wr_data = '0;
    rd_valid = 0; rd_chnl = '0; rd_offset = '0; rd_tag = '0;
    cpl_ready = 0;
    tx_len_i = '0; tx_offlast_i = '0;
    rx_done_len_i = '0; tx_done_len_i = '0;
    core_settings_i = '0; fpga_name_i = '0; intr_i = '0;
    step(); step();
    chk("rst_rd_ready", rd_ready, 1'b1);
    chk("rst_cpl_valid", cpl_valid, 1'b0);
    chk("rst_regs", {63'd0, |{sgrx_addr, sgtx_addr, rx_len}}, 64'd0);
    aresetn = 1'b1;
    step();

    // SG RX list on channel 2
    wr(4'd2, ADDR_SGRX_ADDRLO, 32'h1000);
    wr(4'd2, ADDR_SGRX_ADDRHI, 32'h1);
    wr(4'd2, ADDR_SGRX_LEN, 32'h40);
    chk("sgrx_pulse", sgrx_valid, 64'h004);
    chk("sgrx_addr2", sgrx_addr[2*64 +: 64], 64'h1_0000_1000);
    chk("sgrx_len2", sgrx_len[2*32 +: 32], 64'h40);
    step();
    chk("sgrx_pulse_end", sgrx_valid, 64'h0);

    // RX setup on channel 0
    wr(4'd0, ADDR_RX_LEN, 32'd256);
    chk("rx_start_early", rx_start, 64'h0);
    wr(4'd0, ADDR_RX_OFFLAST, 32'h1);
    chk("rx_start0", rx_start, 64'h001);
    chk("rx_len0", rx_len[31:0], 64'd256);
    step();
    chk("rx_start_end", rx_start, 64'h0);

    // TX_OFFLAST read with back-pressure
    tx_offlast_i[5*32 +: 32] = 32'h8000_0001;
    cpl_ready = 1'b0;
    rd(4'd5, ADDR_TX_OFFLAST, 8'h3A);
    chk("lat_t1_valid", cpl_valid, 1'b0);
    chk("tx_ack5", tx_ack, 64'h020);
    step();
    chk("lat_t2_valid", cpl_valid, 1'b1);
    chk("txofl_data", cpl_data, 64'h8000_0001);
    chk("txofl_tag", cpl_tag, 64'h3A);
    chk("tx_ack_end", tx_ack, 64'h0);
    repeat (3) begin
      step();
      chk("hold_valid", cpl_valid, 1'b1);
      chk("hold_data", cpl_data, 64'h8000_0001);
      chk("hold_ack", tx_ack, 64'h0);
    end
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk("back_idle", rd_ready, 1'b1);

    // Interrupt clear-on-read
    intr_i = 24'h000005;
    rd(4'd0, ADDR_INTR_VECTOR_0, 8'h11);
    chk("intr_clr_capt", intr_clr, 64'h5);
    step();
    intr_i = 24'h000015;
    chk("intr_data", cpl_data, 64'h5);
    chk("intr_clr_after", intr_clr, 64'h0);
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;

    // Invalid channel write and read
    for (int i = 0; i < N; i++) tx_len_i[i*32 +: 32] = 32'hA5A5_0000 + i;
    wr(4'd12, ADDR_SGRX_LEN, 32'h77);
    wr(4'd12, ADDR_RX_OFFLAST, 32'h1);
    chk("bad_wr_pulse", {sgrx_valid, sgtx_valid, rx_start}, 64'h0);
    rd(4'd12, ADDR_TX_LEN, 8'h22);
    step();
    chk("bad_rd_valid", cpl_valid, 1'b1);
    chk("bad_rd_data", cpl_data, 64'h0);
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;

    // Reset while a completion is pending
    fpga_name_i = 32'hF96A_0001;
    rd(4'd3, ADDR_FPGA_NAME, 8'h07);
    step();
    chk("pre_rst_valid", cpl_valid, 1'b1);
    chk("pre_rst_data", cpl_data, 64'hF96A_0001);
    #1 aresetn = 1'b0;
    #1;
    chk("rst_mid_valid", cpl_valid, 1'b0);
    chk("rst_mid_ready", rd_ready, 1'b1);
    step();
    aresetn = 1'b1;
    chk("rst_out_zero",
        {62'd0, |{sgrx_addr, sgtx_addr, rx_len, rx_offlast},
         |{cpl_data, cpl_tag, tx_ack, intr_clr}}, 64'd0);
    chk("rst_out_ready", rd_ready, 1'b1);
    step();

    // Randomized traffic
    repeat (3000) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_chnl   = CW'($urandom_range(0, 13));
      wr_offset = 4'($urandom_range(0, 15));
      wr_data   = $urandom();
      rd_valid  = ($urandom_range(0, 2) != 0);
      rd_chnl   = CW'($urandom_range(0, 13));
      rd_offset = 4'($urandom_range(0, 15));
      rd_tag    = 8'($urandom());
      cpl_ready = ($urandom_range(0, 1) == 1);
      rand_inputs();
      step();
    end
    wr_valid = 0; rd_valid = 0; cpl_ready = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riffa_chnl_reg_ctrl.md
Name: riffa_chnl_reg_ctrl

Overview:
- Host-facing channel register controller for the RIFFA engine layer.
- Decodes 32-bit PCIe register writes and reads, addressed by channel index plus 4-bit register offset, using the shared ADDR_* offset constants.
- Write side: latches scatter-gather and RX transaction setup per channel and issues single-cycle start/valid strobes to the channel engines.
- Read side: sequences completions with a small FSM, acknowledges TX requests, and performs clear-on-read of pending interrupt bits.

Parameters:
- C_NUM_CHNL, 12, number of channels (1..12).
- C_CHNL_W, 4, channel index width.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- wr_valid  in  1  register write strobe.
- wr_chnl  in  C_CHNL_W  write channel index.
- wr_offset  in  OFFSET_W  write register offset.
- wr_data  in  32  write data.
- rd_valid  in  1  register read request.
- rd_ready  out  1  read request accepted.
- rd_chnl  in  C_CHNL_W  read channel index.
- rd_offset  in  OFFSET_W  read register offset.
- rd_tag  in  TAG_W  completion tag.
- cpl_valid  out  1  completion valid.
- cpl_ready  in  1  completion sink ready.
- cpl_data  out  32  completion data.
- cpl_tag  out  TAG_W  echoed tag.
- rx_start  out  C_NUM_CHNL  per-channel RX start pulse.
- rx_len  out  C_NUM_CHNL*SIG_TXRLEN_W  latched RX length.
- rx_offlast  out  C_NUM_CHNL*SIG_OFFLAST_W  latched RX offset/last.
- sgrx_valid  out  C_NUM_CHNL  RX scatter-gather descriptor pulse.
- sgtx_valid  out  C_NUM_CHNL  TX scatter-gather descriptor pulse.
- sgrx_addr  out  C_NUM_CHNL*64  RX scatter-gather list address.
- sgtx_addr  out  C_NUM_CHNL*64  TX scatter-gather list address.
- sgrx_len  out  C_NUM_CHNL*32  RX scatter-gather list length.
- sgtx_len  out  C_NUM_CHNL*32  TX scatter-gather list length.
- tx_len_i  in  C_NUM_CHNL*SIG_TXRLEN_W  TX length reported by each channel.
- tx_offlast_i  in  C_NUM_CHNL*SIG_OFFLAST_W  TX offset/last reported by each channel.
- tx_ack  out  C_NUM_CHNL  TX request acknowledge pulse.
- rx_done_len_i  in  C_NUM_CHNL*SIG_RXDONELEN_W  RX length transferred.
- tx_done_len_i  in  C_NUM_CHNL*SIG_TXDONELEN_W  TX length transferred.
- core_settings_i  in  SIG_CORESETTINGS_W  core settings word.
- fpga_name_i  in  32  FPGA name word.
- intr_i  in  2*C_NUM_CHNL  pending interrupt bits.
- intr_clr  out  2*C_NUM_CHNL  interrupt clear pulse.

Behaviour:
- Reset values: all outputs 0, except rd_ready=1. Latched length and address registers reset to 0. FSM resets to IDLE.
- Write path: always accepted; there is no wr_ready. A write with wr_chnl >= C_NUM_CHNL is dropped with no side effect.
- Write decode by offset:
  - SGRX_ADDRLO / SGRX_ADDRHI load bits [31:0] / [63:32] of sgrx_addr.
  - SGRX_LEN loads sgrx_len; sgrx_valid[ch] pulses for 1 cycle on the following cycle, with the address and length stable.
  - SGTX_* behave identically on the sgtx_* registers.
  - RX_LEN loads rx_len.
  - RX_OFFLAST loads rx_offlast; rx_start[ch] pulses on the following cycle.
  - Writes to readable offsets (1000..1111) are ignored.
- Read FSM states: IDLE, CAPT, CPL.
  - IDLE: rd_ready=1. rd_valid moves the FSM to CAPT and registers chnl, offset and tag.
  - CAPT: muxes the data into cpl_data; moves to CPL.
  - CPL: cpl_valid=1 with data and tag held stable until cpl_ready; on cpl_ready, returns to IDLE.
  - Minimum latency: request accepted at T, cpl_valid at T+2. Throughput is one read per 3 cycles.
- Read data by offset:
  - TX_LEN, TX_OFFLAST, RX_LEN_XFERD and TX_LEN_XFERD return the selected channel's input.
  - CORESETTINGS returns core_settings_i; FPGA_NAME returns fpga_name_i. Both ignore the channel index.
  - INTR_VECTOR_0 returns intr_i zero-extended, bits [31:0]; INTR_VECTOR_1 returns bits [63:32] (0 for C_NUM_CHNL <= 16).
  - Write-only offsets and invalid channels return 0.
- Side effects, all single-cycle pulses in CAPT:
  - A TX_OFFLAST read pulses tx_ack[ch].
  - An INTR_VECTOR_0 read pulses intr_clr equal to exactly the returned bits, so bits set after the capture are not lost.
- Simultaneous write and read: processed independently. A read of a register written in the same cycle returns the new value only if the read's CAPT follows the write cycle.
- Reset mid-read: FSM returns to IDLE, the completion is discarded, and no pulses are emitted.

Decomposition:
- Shared package (riffa_pkg) holds: ADDR_* offsets, SIG_* widths, OFFSET_W, TAG_W, plus a new enum typedef rd_state_t {IDLE, CAPT, CPL}.
- One natural sub-module: riffa_chnl_regs, the per-channel register slice, generated C_NUM_CHNL times. The controller keeps the decode, read mux and FSM.

Test Plan:
- Write ch2: SGRX_ADDRLO=0x1000, SGRX_ADDRHI=0x1, SGRX_LEN=0x40 -> sgrx_valid[2]=1 for exactly 1 cycle; sgrx_addr[2]=0x1_0000_1000; sgrx_len[2]=0x40.
- Write ch0: RX_LEN=256, then RX_OFFLAST=0x1 -> rx_start[0] pulses 1 cycle after the second write; rx_len[0]=256; no other channel pulses.
- Read ch5 TX_OFFLAST, tag 0x3A, tx_offlast_i[5]=0x80000001, cpl_ready held low 4 cycles -> cpl_valid at T+2, stable; data=0x80000001, tag=0x3A; tx_ack[5] exactly 1 pulse.
- intr_i=0x000005, read INTR_VECTOR_0 while intr_i becomes 0x000015 after capture -> cpl_data=0x5; intr_clr=0x5 only.
- Write and read with wr_chnl=12 / rd_chnl=12, C_NUM_CHNL=12 -> no strobes; cpl_data=0.
- aresetn asserted in CPL state -> cpl_valid=0 immediately; after release rd_ready=1 and all outputs are 0.
